// File: rtl/secded_block_decoder.sv
// SECDED (extended Hamming) block decoder co-processor.
// Reads NWORDS codewords from byte memory at SRC_BASE, corrects single-bit
// errors, flags double-bit errors and writes {flags, data} words to DST_BASE.
// The output word must leave room for the two flag bits above the data
// (DW <= 8*BPW-2).
module secded_block_decoder #(
  parameter int DW       = 11,
  parameter int NWORDS   = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int AW       = 8,
  parameter int CNTW     = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            done,
  output logic            busy,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_rd_en,
  input  logic [7:0]      mem_rdata,
  output logic            mem_wr_en,
  output logic [7:0]      mem_wdata,
  output logic [CNTW-1:0] single_cnt,
  output logic [CNTW-1:0] double_cnt
);

  // Smallest P with 2^P >= DW+P+1.
  function automatic int calc_p(input int dw);
    int p;
    p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  // Codeword position of data bit k (skips 0 and powers of two).
  function automatic int data_pos(input int k);
    int n, r;
    n = 0;
    r = 0;
    for (int p = 3; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == k) r = p;
        n++;
      end
    end
    return r;
  endfunction

  localparam int P   = calc_p(DW);
  localparam int CW  = DW + P + 1;
  localparam int BPW = (CW + 7) / 8;
  localparam int OW  = 8 * BPW;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_DEC, S_WR, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_byte;
  logic [AW-1:0]   r_word;
  logic [OW-1:0]   r_raw;
  logic [OW-1:0]   r_out;
  logic            r_done, r_busy, r_rd_en, r_wr_en;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_wdata;
  logic [CNTW-1:0] r_scnt, r_dcnt;

  logic [P-1:0]    w_syn;
  logic            w_par, w_sgl, w_dbl;
  logic [DW-1:0]   w_data;
  logic [OW-1:0]   w_out;

  // Syndrome / overall parity classification of the captured codeword.
  always_comb begin
    w_syn = '0;
    for (int p = 1; p < CW; p++)
      if (r_raw[p]) w_syn = w_syn ^ P'(p);
    w_par = ^r_raw[CW-1:0];
    w_sgl = w_par && (int'(w_syn) < CW);
    w_dbl = !w_sgl && (w_par || (w_syn != '0));
  end

  // Data extraction; a corrected single error only matters when it hits a data position.
  for (genvar k = 0; k < DW; k++) begin : g_data
    localparam int POS = data_pos(k);
    assign w_data[k] = r_raw[POS] ^ (w_sgl & (w_syn == P'(POS)));
  end

  // Output word assembly: flags in the top two bits, data at the bottom.
  always_comb begin
    w_out         = '0;
    w_out[DW-1:0] = w_data;
    w_out[OW-1]   = w_dbl;
    w_out[OW-2]   = w_sgl;
  end

  // Control FSM with registered memory strobes, status and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_byte  <= '0;
      r_word  <= '0;
      r_raw   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_scnt  <= '0;
      r_dcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RD;
            r_word  <= '0;
            r_byte  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_scnt  <= '0;
            r_dcnt  <= '0;
            r_rd_en <= 1'b1;
            r_addr  <= AW'(SRC_BASE);
          end
        end
        S_RD: begin
          // byte b returns one cycle after its read, i.e. while r_byte == b+1
          for (int b = 0; b < BPW - 1; b++)
            if (r_byte == 3'(b + 1)) r_raw[8*b +: 8] <= mem_rdata;
          if (r_byte == 3'(BPW - 1)) begin
            r_rd_en <= 1'b0;
            r_state <= S_WAIT;
          end else begin
            r_byte <= r_byte + 3'd1;
            r_addr <= r_addr + 1'b1;
          end
        end
        S_WAIT: begin
          r_raw[OW-1 -: 8] <= mem_rdata;
          r_state          <= S_DEC;
        end
        S_DEC: begin
          if (w_sgl && (r_scnt != '1)) r_scnt <= r_scnt + 1'b1;
          if (w_dbl && (r_dcnt != '1)) r_dcnt <= r_dcnt + 1'b1;
          // remaining bytes are shifted out of r_out, low byte goes first
          r_out   <= w_out >> 8;
          r_wdata <= w_out[7:0];
          r_wr_en <= 1'b1;
          r_addr  <= AW'(DST_BASE) + AW'(BPW) * r_word;
          r_byte  <= '0;
          r_state <= S_WR;
        end
        S_WR: begin
          if (r_byte == 3'(BPW - 1)) begin
            r_wr_en <= 1'b0;
            r_byte  <= '0;
            if (r_word == AW'(NWORDS - 1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_word  <= r_word + 1'b1;
              r_state <= S_RD;
              r_rd_en <= 1'b1;
              r_addr  <= AW'(SRC_BASE) + AW'(BPW) * (r_word + 1'b1);
            end
          end else begin
            r_byte  <= r_byte + 3'd1;
            r_addr  <= r_addr + 1'b1;
            r_wdata <= r_out[7:0];
            r_out   <= r_out >> 8;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done       = r_done;
  assign busy       = r_busy;
  assign mem_addr   = r_addr;
  assign mem_rd_en  = r_rd_en;
  assign mem_wr_en  = r_wr_en;
  assign mem_wdata  = r_wdata;
  assign single_cnt = r_scnt;
  assign double_cnt = r_dcnt;

endmodule

// File: doc/secded_block_decoder.md
Name: secded_block_decoder

Overview:
Parametrised SECDED (extended Hamming) decoder engine that walks a block of encoded words in byte-wide data memory. For each word it corrects single-bit errors, flags double-bit errors, and writes the decoded data plus 2 status flags to a destination region. It runs as a start/done co-processor beside the core's data memory. It generalises the fixed 11-bit/16-bit program-2 decode to any data width 4..26 and any block length, and adds error counters.

Parameters:
DW, 11, data bits per word (4..26)
NWORDS, 15, words per block (1..2^AW/BPW/2)
SRC_BASE, 30, byte address of first encoded word
DST_BASE, 0, byte address of first decoded word
AW, 8, memory address width
CNTW, 8, error counter width
Derived (localparam): P = smallest P with 2^P >= DW+P+1; CW = DW+P+1; BPW = ceil(CW/8). Require DW <= 8*BPW-2.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  1-cycle pulse, begin block decode
done  out  1  high from block completion until next accepted start
busy  out  1  high while the FSM is not IDLE/DONE
mem_addr  out  AW  byte address
mem_rd_en  out  1  read strobe; mem_rdata is valid the following cycle
mem_rdata  in  8  read data
mem_wr_en  out  1  write strobe, committed at clk edge
mem_wdata  out  8  write data
single_cnt  out  CNTW  words with a corrected single error, saturating
double_cnt  out  CNTW  words flagged as double error, saturating

Behaviour:
- Reset (async, asserted or mid-operation): FSM to IDLE; done, busy, mem_rd_en, mem_wr_en, counters = 0; mem_addr, mem_wdata = 0. No further memory writes are issued.
- Codeword layout: bit 0 = overall parity; bits at positions 2^k (1,2,4,..) = Hamming parity; remaining positions 3,5,6,7,9,.. hold data LSB-first. Bytes are little-endian: byte b of word i is at SRC_BASE + BPW*i + b. Bits above CW-1 in the top byte are ignored.
- Decode: syn = XOR of position indices of all set bits in 1..CW-1; par = XOR of all CW bits.
  syn=0, par=0 -> no error, flags 00.
  par=1, syn<CW -> single error, flip bit syn (syn=0 means bit 0), flags 01, single_cnt++.
  par=0, syn!=0 -> double error, flags 10, uncorrected data, double_cnt++.
  par=1, syn>=CW (shortened code) -> treat as double error, flags 10.
- Output word: 8*BPW bits, flags at [8*BPW-1:8*BPW-2], data at [DW-1:0], zeros elsewhere. Written little-endian at DST_BASE + BPW*i + b.
- FSM states: IDLE, RD, WAIT, DEC, WR, DONE.
  IDLE/DONE + start -> RD with word index 0. Counters clear and done drops on the accepted start cycle.
  RD: BPW cycles, one byte read per cycle. Each byte is captured the cycle after its read.
  WAIT: 1 cycle to capture the last byte.
  DEC: 1 cycle, decoded result registered.
  WR: BPW cycles, one byte write per cycle.
  After WR: if i = NWORDS-1, go to DONE, else i+1 and go to RD.
- Per-word latency: 2*BPW+2 cycles (6 for DW=11). done rises NWORDS*(2*BPW+2) cycles after the start edge: 90 cycles for defaults.
- start while busy is ignored. Read and write strobes are never asserted in the same cycle.
- Counters saturate at 2^CNTW-1 and hold their value in DONE.

Test Plan:
- Defaults, all 15 source words = 0x0000 -> all destinations 0x0000; done at cycle 90; both counters 0.
- Data 0x7FF encoded as 0xFFFF, no flips -> output 0x07FF, flags 00.
- Data 0x000 with codeword bit 3 flipped (0x0008) -> output 0x4000, single_cnt=1. Same data with only bit 0 flipped (0x0001) -> output 0x4000.
- Data 0x000 with codeword bits 3 and 5 flipped (0x0028) -> output 0x8003, double_cnt=1.
- Random 15-word block with a 75/25 mix of 1-bit and 2-bit flips -> outputs match the bench model for every word. Counters equal the injected counts. A start pulse issued mid-run is ignored.
- Reset asserted at cycle 20 -> outputs 0 immediately, no writes after reset. A new start then completes normally. Also run DW=26 (CW=32, BPW=4): 0x3FFFFFF with bit 17 flipped -> 0x43FFFFFF.
